// File: rtl/spi_master_tx.sv
// SPI mode-0 byte transmitter with frame-level chip select.
// Bytes arrive on a valid/ready handshake and are shifted out MSB first.
module spi_master_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_val,
    input  logic       in_last,
    output logic       in_rdy,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    output logic       busy
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 4;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             last_q, last_nxt;
    logic             sclk_nxt, mosi_nxt, cs_nxt, in_rdy_nxt, busy_nxt;
    logic             accept, div_done;

    assign accept   = in_val && in_rdy;
    assign div_done = (div_cnt == DIV_MAX);

    // State and every output are flops; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            last_q  <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            in_rdy  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            last_q  <= last_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
            in_rdy  <= in_rdy_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        last_nxt  = last_q;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;

        case (state)
            IDLE, NEXT: begin
                if (accept) begin
                    state_nxt = SETUP;
                    shreg_nxt = in_data;
                    last_nxt  = in_last;
                    mosi_nxt  = in_data[7];
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    state_nxt = SHIFT;
                    sclk_nxt  = 1'b1;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_nxt  = '0;
                    sclk_nxt = !sclk;
                    // Falling edge: advance to the next bit, or finish the byte on the 8th fall.
                    if (sclk) begin
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = last_q ? HOLD : NEXT;
                            bit_nxt   = '0;
                        end else begin
                            bit_nxt   = bit_cnt + BIT_W'(1);
                            mosi_nxt  = shreg[6];
                            shreg_nxt = {shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_done) begin
                    state_nxt = GAP;
                    mosi_nxt  = 1'b0;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            GAP: begin
                // Two divider periods, with bit_cnt marking the second one.
                if (div_done) begin
                    div_nxt = '0;
                    if (bit_cnt == BIT_W'(1)) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = BIT_W'(1);
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
            end
        endcase

        cs_nxt     = (state_nxt == IDLE) || (state_nxt == GAP);
        in_rdy_nxt = (state_nxt == IDLE) || (state_nxt == NEXT);
        busy_nxt   = (state_nxt != IDLE);
    end
endmodule
